// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI arbiter slice.
package spi_pkg;

   localparam int unsigned SPI_DATA_W = 12;

   typedef enum logic [1:0] {
      IDLE,
      START,
      XFER,
      FIN
   } spi_arb_state_t;

endpackage

// File: rtl/spi_rr_pick.sv
// Round-robin winner search: first set request bit at or after rr_ptr, wrapping.
module spi_rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] win_oh,
   output logic [IDX_W-1:0]   win_idx,
   output logic               valid
);

   int unsigned cand;

   always_comb begin
      win_oh  = '0;
      win_idx = '0;
      valid   = 1'b0;
      cand    = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = 32'(rr_ptr) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!valid && req[IDX_W'(cand)]) begin
            valid                 = 1'b1;
            win_idx               = IDX_W'(cand);
            win_oh[IDX_W'(cand)]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ clients, one frame per grant.
// Optional frame-phase timeout with err pulse enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arbiter
   import spi_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned DATA_W      = SPI_DATA_W,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        done,
   output logic                      busy,
   output logic                      spi_new_data,
   output logic [DATA_W-1:0]         spi_data_in,
   input  logic                      spi_cs,
   output logic                      err
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_W < 1 || TIMEOUT_CYC < 1) begin : g_cfg_chk
      $error("spi_arbiter: unsupported parameter set");
   end

   spi_arb_state_t       state;
   logic [1:0]           cs_sync;
   logic                 cs_s;
   logic [IDX_W-1:0]     rr_ptr;
   logic [IDX_W-1:0]     win_idx;
   logic [IDX_W-1:0]     rr_next;
   logic [NUM_REQ-1:0]   pick_oh;
   logic [IDX_W-1:0]     pick_idx;
   logic                 pick_valid;
   logic                 frame_end;
   logic                 tmo_end;
   logic [DATA_W-1:0]    req_word [NUM_REQ];

   assign cs_s = cs_sync[1];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_word
      assign req_word[i] = req_data[i*DATA_W +: DATA_W];
   end

   spi_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req     (req),
      .rr_ptr  (rr_ptr),
      .win_oh  (pick_oh),
      .win_idx (pick_idx),
      .valid   (pick_valid)
   );

   assign rr_next = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TMO_W-1:0] tmo;
   logic             tmo_hit;

   assign tmo_hit = (tmo == TMO_W'(TIMEOUT_CYC - 1));

   // A phase times out only if it would not otherwise advance this cycle.
   always_comb begin
      tmo_end = 1'b0;
      if (tmo_hit && ((state == START && cs_s) || (state == XFER && !cs_s))) tmo_end = 1'b1;
   end
`else
   assign tmo_end = 1'b0;
   assign err     = 1'b0;
`endif

   assign frame_end = ((state == XFER) && cs_s) || tmo_end;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cs_sync      <= 2'b11;
         rr_ptr       <= '0;
         win_idx      <= '0;
         gnt          <= '0;
         done         <= '0;
         busy         <= 1'b0;
         spi_new_data <= 1'b0;
         spi_data_in  <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
         tmo          <= '0;
         err          <= 1'b0;
`endif
      end else begin
         cs_sync <= {cs_sync[0], spi_cs};
         done    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
         err     <= 1'b0;
         tmo     <= tmo + TMO_W'(1);
`endif
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  gnt          <= pick_oh;
                  win_idx      <= pick_idx;
                  spi_data_in  <= req_word[pick_idx];
                  spi_new_data <= 1'b1;
                  busy         <= 1'b1;
                  state        <= START;
`ifdef SPI_ARB_TIMEOUT_EN
                  tmo          <= '0;
`endif
               end
            end
            START: begin
               if (!cs_s) begin
                  spi_new_data <= 1'b0;
                  state        <= XFER;
`ifdef SPI_ARB_TIMEOUT_EN
                  tmo          <= '0;
`endif
               end
            end
            XFER:    state <= XFER;
            FIN:     state <= IDLE;
            default: state <= IDLE;
         endcase

         // Frame close: done/err pulse, release grant and advance the pointer.
         if (frame_end) begin
            done         <= gnt;
            gnt          <= '0;
            busy         <= 1'b0;
            spi_new_data <= 1'b0;
            rr_ptr       <= rr_next;
            state        <= FIN;
`ifdef SPI_ARB_TIMEOUT_EN
            err          <= tmo_end;
`endif
         end
      end
   end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a small behavioural SPI master (LSB first, 4 clk per bit).
module tb_spi_arbiter;

   localparam int unsigned NR = 4;
   localparam int unsigned DW = 12;

   logic            clk = 1'b0;
   logic            rst;
   logic [NR-1:0]   req;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]   gnt;
   logic [NR-1:0]   done;
   logic            busy;
   logic            spi_new_data;
   logic [DW-1:0]   spi_data_in;
   logic            spi_cs;
   logic            err;

   int n_chk = 0;
   int n_err = 0;

   logic            master_en;
   logic            m_busy;
   logic            m_cs;
   logic [5:0]      m_cnt;
   logic [3:0]      m_bit;
   logic [DW-1:0]   m_shift;
   logic [DW-1:0]   m_rx;
   logic [DW-1:0]   rx_word;
   logic            mosi;
   logic [DW-1:0]   dval [NR];

   always #5 clk = ~clk;

   spi_arbiter #(
      .NUM_REQ     (NR),
      .DATA_W      (DW),
      .TIMEOUT_CYC (64)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .req_data     (req_data),
      .gnt          (gnt),
      .done         (done),
      .busy         (busy),
      .spi_new_data (spi_new_data),
      .spi_data_in  (spi_data_in),
      .spi_cs       (spi_cs),
      .err          (err)
   );

   // Behavioural SPI master: starts on new_data when idle, reset by the shared rst.
   assign m_bit  = m_cnt[5:2];
   assign mosi   = m_busy ? m_shift[m_bit] : 1'b0;
   assign spi_cs = m_cs;

   always @(posedge clk) begin
      if (rst) begin
         m_busy  <= 1'b0;
         m_cs    <= 1'b1;
         m_cnt   <= '0;
         m_shift <= '0;
         m_rx    <= '0;
         rx_word <= '0;
      end else if (!m_busy) begin
         if (spi_new_data && master_en) begin
            m_busy  <= 1'b1;
            m_cs    <= 1'b0;
            m_cnt   <= '0;
            m_shift <= spi_data_in;
         end
      end else begin
         if (m_cnt[1:0] == 2'd2) m_rx[m_bit] <= mosi;
         if (m_cnt == 6'd47) begin
            m_busy  <= 1'b0;
            m_cs    <= 1'b1;
            rx_word <= m_rx;
         end
         m_cnt <= m_cnt + 6'd1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rst_pulse();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic set_data(input int idx, input logic [DW-1:0] val);
      req_data[idx*DW +: DW] = val;
   endtask

   task automatic wait_done();
      int n = 0;
      while (done == '0 && n < 400) begin
         tick();
         n++;
      end
      if (done == '0) check("done_wait", 32'(0), 32'(1));
   endtask

   task automatic wait_gnt();
      int n = 0;
      while (gnt == '0 && n < 400) begin
         tick();
         n++;
      end
      if (gnt == '0) check("gnt_wait", 32'(0), 32'(1));
   endtask

   initial begin
      int n;
      int e;
      rst       = 1'b1;
      req       = '0;
      req_data  = '0;
      master_en = 1'b1;
      dval[0] = 12'h111;
      dval[1] = 12'h222;
      dval[2] = 12'h333;
      dval[3] = 12'h444;
      tick();
      tick();
      rst = 1'b0;

      // Reset values
      check("rst_gnt",  32'(gnt), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_nd",   32'(spi_new_data), 32'(0));
      check("rst_din",  32'(spi_data_in), 32'(0));
      check("rst_err",  32'(err), 32'(0));

      // 1: single client, one-cycle grant latency
      set_data(0, 12'hA5C);
      req = 4'b0001;
      tick();
      check("t1_gnt",  32'(gnt), 32'h1);
      check("t1_nd",   32'(spi_new_data), 32'(1));
      check("t1_busy", 32'(busy), 32'(1));
      check("t1_din",  32'(spi_data_in), 32'hA5C);
      req = '0;
      wait_done();
      check("t1_done", 32'(done), 32'h1);
      check("t1_busy_end", 32'(busy), 32'(0));
      check("t1_gnt_end", 32'(gnt), 32'(0));
      check("t1_mosi", 32'(rx_word), 32'hA5C);
      check("t1_err",  32'(err), 32'(0));
      tick();
      check("t1_done_pulse", 32'(done), 32'(0));

      // 2: all clients requesting, order 0,1,2,3,0
      rst_pulse();
      for (int i = 0; i < NR; i++) set_data(i, dval[i]);
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         e = k % NR;
         wait_gnt();
         check("t2_gnt", 32'(gnt), 32'(1) << e);
         wait_done();
         check("t2_done", 32'(done), 32'(1) << e);
         check("t2_mosi", 32'(rx_word), 32'(dval[e]));
         if (k == 4) req = '0;
      end
      tick();
      tick();
      check("t2_idle", 32'(gnt), 32'(0));

      // 3: request arriving mid-frame, one idle cycle between frames
      rst_pulse();
      set_data(0, 12'h0F1);
      set_data(2, 12'hC3E);
      req = 4'b0001;
      tick();
      req = '0;
      repeat (20) tick();
      req = 4'b0100;
      wait_done();
      check("t3_done0", 32'(done), 32'h1);
      tick();
      check("t3_gap", 32'(gnt), 32'(0));
      tick();
      check("t3_gnt2", 32'(gnt), 32'h4);
      req = '0;
      wait_done();
      check("t3_done2", 32'(done), 32'h4);
      check("t3_mosi", 32'(rx_word), 32'hC3E);

      // 4: reset during XFER aborts without done
      rst_pulse();
      set_data(1, 12'h7E1);
      req = 4'b0010;
      tick();
      req = '0;
      repeat (20) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t4_gnt",  32'(gnt), 32'(0));
      check("t4_busy", 32'(busy), 32'(0));
      check("t4_nd",   32'(spi_new_data), 32'(0));
      check("t4_done", 32'(done), 32'(0));
      n = 0;
      repeat (80) begin
         tick();
         if (done != '0) n++;
      end
      check("t4_nodone", 32'(n), 32'(0));
      set_data(3, 12'h9B2);
      req = 4'b1000;
      tick();
      check("t4_gnt3", 32'(gnt), 32'h8);
      req = '0;
      wait_done();
      check("t4_done3", 32'(done), 32'h8);
      check("t4_mosi", 32'(rx_word), 32'h9B2);

      // 6: req drop and data change after grant are ignored
      rst_pulse();
      set_data(1, 12'h3C7);
      req = 4'b0010;
      tick();
      check("t6_gnt", 32'(gnt), 32'h2);
      set_data(1, 12'hFFF);
      repeat (10) tick();
      req = '0;
      check("t6_din", 32'(spi_data_in), 32'h3C7);
      wait_done();
      check("t6_done", 32'(done), 32'h2);
      check("t6_mosi", 32'(rx_word), 32'h3C7);

`ifdef SPI_ARB_TIMEOUT_EN
      // 5: cs stuck high, timeout after 64 clk in START
      rst_pulse();
      master_en = 1'b0;
      set_data(0, 12'h5A5);
      req = 4'b0001;
      tick();
      check("t5_gnt", 32'(gnt), 32'h1);
      req = '0;
      n = 0;
      while (done == '0 && n < 200) begin
         tick();
         n++;
      end
      check("t5_cycles", 32'(n), 32'(64));
      check("t5_err",  32'(err), 32'(1));
      check("t5_done", 32'(done), 32'h1);
      master_en = 1'b1;
      set_data(1, 12'h1D4);
      req = 4'b0010;
      wait_gnt();
      check("t5_gnt1", 32'(gnt), 32'h2);
      req = '0;
      wait_done();
      check("t5_done1", 32'(done), 32'h2);
      check("t5_mosi", 32'(rx_word), 32'h1D4);
      check("t5_err_clr", 32'(err), 32'(0));
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
